vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Parametrised VGA raster timing generator for the game display path.
//  - Derives a pixel tick from the system clock and runs horizontal/vertical raster counters.
//  - Produces sync, display-enable, position and frame/line strobes.
//  - Sync and display-enable are delayed by a programmable number of pixel ticks, so they line up with a pipelined pixel renderer.
//  - Instantiated once inside game_top; replaces the fixed 640x480 counter logic.
// PARAMETERS
//  CLK_DIV     2    system clocks per pixel; even, >=2 (50 MHz -> 25 MHz pixel)
//  H_ACTIVE    640  visible pixels per line
//  H_FP        16   horizontal front porch, pixels
//  H_SYNC      96   horizontal sync width, pixels
//  H_BP        48   horizontal back porch, pixels
//  V_ACTIVE    480  visible lines per frame
//  V_FP        10   vertical front porch, lines
//  V_SYNC      2    vertical sync width, lines
//  V_BP        33   vertical back porch, lines
//  H_SYNC_POL  0    hsync active level (0 = active-low)
//  V_SYNC_POL  0    vsync active level (0 = active-low)
//  OUT_DELAY   0    pixel ticks of delay on hsync/vsync/display_enable, 0..7
//  POS_W       10   width of hpos_o/vpos_o; must hold H_TOTAL-1 and V_TOTAL-1
// PORTS
//  clk_i             in   1      system clock
//  reset_ni          in   1      asynchronous reset, active-low
//  enable_i          in   1      run raster; low = hold in reset state (synchronous)
//  pix_tick_o        out  1      one-clk pulse, pixel counters advance this cycle
//  VGA_clk_o         out  1      pixel clock to DAC, 50% duty
//  hpos_o            out  POS_W  current horizontal count, undelayed
//  vpos_o            out  POS_W  current vertical count, undelayed
//  display_enable_o  out  1      visible region, delayed OUT_DELAY ticks
//  hsync_no          out  1      horizontal sync, polarity per H_SYNC_POL, delayed
//  vsync_no          out  1      vertical sync, polarity per V_SYNC_POL, delayed
//  line_start_o      out  1      one-clk pulse when hpos wraps to 0
//  frame_start_o     out  1      one-clk pulse when (hpos,vpos) wraps to (0,0)
// BEHAVIOUR
//  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
//  - Reset (async, reset_ni=0), and enable_i=0 (sync):
//    - div_cnt, hpos_o, vpos_o = 0; delay line cleared.
//    - pix_tick_o, VGA_clk_o, display_enable_o, line/frame strobes = 0.
//    - hsync_no = ~H_SYNC_POL; vsync_no = ~V_SYNC_POL.
//  - Divider: div_cnt counts 0..CLK_DIV-1 and wraps. pix_tick_o=1 in the cycle div_cnt==CLK_DIV-1.
//  - VGA_clk_o is registered; it is 1 when the updated div_cnt >= CLK_DIV/2.
//  - Counters are all registered and update only on clock edges where pix_tick_o=1:
//    - hpos: hpos==H_TOTAL-1 -> 0, else +1.
//    - vpos advances only when hpos wraps; vpos==V_TOTAL-1 -> 0.
//  - line_start_o and frame_start_o are asserted in the clk cycle in which the new 0 value is visible on hpos_o (and on vpos_o for frame_start_o).
//    - The first (0,0) after reset or enable does not pulse; the first frame_start_o follows a full frame.
//  - Raw, combinational from current counts:
//    - de = hpos<H_ACTIVE && vpos<V_ACTIVE.
//    - hs active for H_ACTIVE+H_FP <= hpos < H_ACTIVE+H_FP+H_SYNC.
//    - vs active for V_ACTIVE+V_FP <= vpos < V_ACTIVE+V_FP+V_SYNC.
//    - Active means driven at the POL level.
//  - Output registers for {de,hs,vs}:
//    - OUT_DELAY=0: outputs are the raw {de,hs,vs} registered on pix_tick, so they always match hpos_o/vpos_o.
//    - OUT_DELAY=N: a N-stage shift register, shifting only on pix_tick, sits after that register. The outputs lag hpos_o/vpos_o by exactly N pixel ticks.
//  - Wrap-around: sync pulses spanning the frame boundary through the delay line must not glitch; the delay line does not clear on frame_start.
//  - A reset or enable_i drop mid-frame takes effect immediately; the raster restarts at (0,0) with div_cnt=0.
// STRUCTURE
//  - vga_pkg (shared): timing_t struct {active,fp,sync,bp}; localparams VGA_640x480_60, VGA_800x600_72; function total(timing_t).
//  - Sub-module sync_delay_line #(DEPTH,W=3): tick-gated shift register, async active-low clear, passthrough when DEPTH=0.
//  - Elaboration-time assertions: CLK_DIV even and >=2; H_TOTAL, V_TOTAL < 2**POS_W; OUT_DELAY<=7.
// TESTING
//  1. Defaults; release reset, enable_i=1 -> pix_tick every 2nd clk; frame_start_o period 840000 clks (800*525*2); VGA_clk_o 50% duty.
//  2. Defaults, OUT_DELAY=0 -> hsync_no=0 exactly while hpos_o in 656..751 (96 ticks); vsync_no=0 for vpos_o 490..491; display_enable_o=1 for 640x480 ticks per frame.
//  3. OUT_DELAY=3 -> display_enable_o rises 3 ticks after hpos_o=0 on line 0; hsync_no falls when hpos_o=659.
//  4. Sync edge across the frame wrap -> delay line keeps pulse widths unchanged and no glitch at the wrap.
//  5. Reset asserted at hpos=300, vpos=200, mid-tick -> all outputs at reset values the same cycle; after release, the first frame_start_o arrives after a full 840000 clks.
//  6. enable_i low for 10 clks mid-line -> counters held at 0, syncs inactive, no strobes. 800x600_72 params with CLK_DIV=2 -> H_TOTAL 1040, V_TOTAL 666; hsync at hpos 856..975, active-high when H_SYNC_POL=1.

Source files
------------

// File: rtl/vga_timing_gen_pkg.sv
// Shared VGA timing definitions: per-axis timing record, standard modes,
// and the bit layout of the {de,hs,vs} sync vector.
package vga_timing_gen_pkg;

  typedef struct packed {
    int unsigned active;
    int unsigned fp;
    int unsigned sync;
    int unsigned bp;
  } timing_t;

  typedef struct packed {
    timing_t h;
    timing_t v;
  } mode_t;

  localparam mode_t VGA_640x480_60 = '{
    h: '{active: 640, fp: 16, sync: 96,  bp: 48},
    v: '{active: 480, fp: 10, sync: 2,   bp: 33}
  };

  localparam mode_t VGA_800x600_72 = '{
    h: '{active: 800, fp: 56, sync: 120, bp: 64},
    v: '{active: 600, fp: 37, sync: 6,   bp: 23}
  };

  // Bit positions inside the sync vector; bits hold "active" flags,
  // polarity is applied only at the output pins.
  localparam int SIG_DE = 0;
  localparam int SIG_HS = 1;
  localparam int SIG_VS = 2;
  localparam int SIG_W  = 3;

  function automatic int unsigned total(timing_t t);
    return t.active + t.fp + t.sync + t.bp;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster output bundle of the VGA timing generator.
interface vga_timing_gen_if
  import vga_timing_gen_pkg::*;
#(
  parameter int POS_W = 10
);
  logic             pix_tick_o;
  logic             VGA_clk_o;
  logic [POS_W-1:0] hpos_o;
  logic [POS_W-1:0] vpos_o;
  logic             display_enable_o;
  logic             hsync_no;
  logic             vsync_no;
  logic             line_start_o;
  logic             frame_start_o;

  modport master (
    output pix_tick_o, VGA_clk_o, hpos_o, vpos_o, display_enable_o,
           hsync_no, vsync_no, line_start_o, frame_start_o
  );

  modport slave (
    input  pix_tick_o, VGA_clk_o, hpos_o, vpos_o, display_enable_o,
           hsync_no, vsync_no, line_start_o, frame_start_o
  );
endinterface

// File: rtl/vga_timing_gen_sync_delay_line.sv
// Tick-gated shift register used to retard the sync vector so it lines up
// with a pipelined pixel renderer. DEPTH=0 is a plain wire.
module sync_delay_line
  import vga_timing_gen_pkg::*;
#(
  parameter int DEPTH = 0,
  parameter int W     = SIG_W
) (
  input  logic         clk_i,
  input  logic         reset_ni,
  input  logic         clr_i,
  input  logic         tick_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  if (DEPTH == 0) begin : g_pass
    logic unused_ctl;
    assign unused_ctl = ^{clk_i, reset_ni, clr_i, tick_i};
    assign q_o = d_i;
  end else begin : g_shift
    logic [W-1:0] sr_q [DEPTH];

    // Shift one stage per pixel tick; clear on reset or raster disable.
    always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
        for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
      end else if (clr_i) begin
        for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
      end else if (tick_i) begin
        sr_q[0] <= d_i;
        for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
      end
    end

    assign q_o = sr_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-tick divider, h/v raster counters,
// line/frame strobes and a delayable {de,hsync,vsync} output path.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter bit          H_SYNC_POL = 1'b0,
  parameter bit          V_SYNC_POL = 1'b0,
  parameter int unsigned OUT_DELAY  = 0,
  parameter int unsigned POS_W      = 10
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              enable_i,
  vga_timing_gen_if.master  vga
);

  localparam timing_t     H_TIM   = '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP};
  localparam timing_t     V_TIM   = '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP};
  localparam int unsigned H_TOTAL = total(H_TIM);
  localparam int unsigned V_TOTAL = total(V_TIM);
  localparam int          DIV_W   = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [POS_W-1:0] H_LAST   = POS_W'(H_TOTAL - 1);
  localparam logic [POS_W-1:0] V_LAST   = POS_W'(V_TOTAL - 1);
  localparam logic [POS_W-1:0] H_VIS    = POS_W'(H_ACTIVE);
  localparam logic [POS_W-1:0] V_VIS    = POS_W'(V_ACTIVE);
  localparam logic [POS_W-1:0] HS_BEG   = POS_W'(H_ACTIVE + H_FP);
  localparam logic [POS_W-1:0] HS_END   = POS_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [POS_W-1:0] VS_BEG   = POS_W'(V_ACTIVE + V_FP);
  localparam logic [POS_W-1:0] VS_END   = POS_W'(V_ACTIVE + V_FP + V_SYNC);

  if (CLK_DIV < 2 || (CLK_DIV % 2) != 0) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be even and >= 2");
  end
  if (H_TOTAL >= (1 << POS_W) || V_TOTAL >= (1 << POS_W)) begin : g_bad_pos
    $error("vga_timing_gen: POS_W too narrow for H_TOTAL/V_TOTAL");
  end
  if (OUT_DELAY > 7) begin : g_bad_dly
    $error("vga_timing_gen: OUT_DELAY must be 0..7");
  end

  logic [DIV_W-1:0] div_q, div_d;
  logic             vclk_q, vclk_d;
  logic [POS_W-1:0] hpos_q, hpos_d;
  logic [POS_W-1:0] vpos_q, vpos_d;
  logic             ls_q, ls_d;
  logic             fs_q, fs_d;
  logic [SIG_W-1:0] sig_q, sig_d;
  logic [SIG_W-1:0] sig_dly;
  logic             pix_tick;
  logic             h_wrap;
  logic             v_wrap;

  // Next-state for divider, raster counters, strobes and the raw sync
  // vector; the sync vector is computed from the post-tick counts so the
  // undelayed outputs always agree with hpos_o/vpos_o.
  always_comb begin
    pix_tick = (div_q == DIV_LAST);
    h_wrap   = (hpos_q == H_LAST);
    v_wrap   = (vpos_q == V_LAST);
    div_d    = pix_tick ? '0 : div_q + 1'b1;
    vclk_d   = (div_d >= DIV_HALF);
    hpos_d   = hpos_q;
    vpos_d   = vpos_q;
    sig_d    = sig_q;
    if (pix_tick) begin
      hpos_d = h_wrap ? '0 : hpos_q + 1'b1;
      if (h_wrap) vpos_d = v_wrap ? '0 : vpos_q + 1'b1;
      sig_d[SIG_DE] = (hpos_d < H_VIS) && (vpos_d < V_VIS);
      sig_d[SIG_HS] = (hpos_d >= HS_BEG) && (hpos_d < HS_END);
      sig_d[SIG_VS] = (vpos_d >= VS_BEG) && (vpos_d < VS_END);
    end
    ls_d = pix_tick && h_wrap;
    fs_d = ls_d && v_wrap;
  end

  // State registers; disable behaves like a synchronous reset.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      div_q  <= '0;
      vclk_q <= 1'b0;
      hpos_q <= '0;
      vpos_q <= '0;
      ls_q   <= 1'b0;
      fs_q   <= 1'b0;
      sig_q  <= '0;
    end else if (!enable_i) begin
      div_q  <= '0;
      vclk_q <= 1'b0;
      hpos_q <= '0;
      vpos_q <= '0;
      ls_q   <= 1'b0;
      fs_q   <= 1'b0;
      sig_q  <= '0;
    end else begin
      div_q  <= div_d;
      vclk_q <= vclk_d;
      hpos_q <= hpos_d;
      vpos_q <= vpos_d;
      ls_q   <= ls_d;
      fs_q   <= fs_d;
      sig_q  <= sig_d;
    end
  end

  sync_delay_line #(
    .DEPTH (OUT_DELAY),
    .W     (SIG_W)
  ) u_dly (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .clr_i    (!enable_i),
    .tick_i   (pix_tick),
    .d_i      (sig_q),
    .q_o      (sig_dly)
  );

  assign vga.pix_tick_o       = pix_tick;
  assign vga.VGA_clk_o        = vclk_q;
  assign vga.hpos_o           = hpos_q;
  assign vga.vpos_o           = vpos_q;
  assign vga.line_start_o     = ls_q;
  assign vga.frame_start_o    = fs_q;
  assign vga.display_enable_o = sig_dly[SIG_DE];
  assign vga.hsync_no         = sig_dly[SIG_HS] ? H_SYNC_POL : ~H_SYNC_POL;
  assign vga.vsync_no         = sig_dly[SIG_VS] ? V_SYNC_POL : ~V_SYNC_POL;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (small raster no delay, small
// raster with CLK_DIV=4 / delay 3 / active-high syncs, 800x600 timing)
// checked every cycle against an arithmetic raster model, plus literal
// expectations for periods, pulse widths and edge positions.
module tb_vga_timing_gen;
  import vga_timing_gen_pkg::*;

  typedef struct {
    int tick, vclk, h, v, de, hs, vs, ls, fs;
  } obs_t;

  typedef struct {
    int div, ha, hf, hs, hb, va, vf, vs, vb, dly;
    bit hp, vp;
  } cfg_t;

  cfg_t cfg_a = '{div: 2, ha: 8, hf: 2, hs: 3, hb: 3, va: 4, vf: 1, vs: 2, vb: 1,
                  dly: 0, hp: 1'b0, vp: 1'b0};
  cfg_t cfg_b = '{div: 4, ha: 8, hf: 2, hs: 3, hb: 3, va: 4, vf: 1, vs: 2, vb: 1,
                  dly: 3, hp: 1'b1, vp: 1'b1};
  cfg_t cfg_c = '{div: 2, ha: 800, hf: 56, hs: 120, hb: 64, va: 600, vf: 37, vs: 6, vb: 23,
                  dly: 0, hp: 1'b1, vp: 1'b1};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  bit   chk_on = 1'b0;
  int   cyc = 0;
  int   k = 0;
  int   checks = 0;
  int   failures = 0;

  vga_timing_gen_if #(.POS_W(5))  ifa ();
  vga_timing_gen_if #(.POS_W(5))  ifb ();
  vga_timing_gen_if #(.POS_W(11)) ifc ();

  vga_timing_gen #(
    .CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .OUT_DELAY(0), .POS_W(5)
  ) dut_a (.clk_i(clk), .reset_ni(rst_n), .enable_i(en), .vga(ifa));

  vga_timing_gen #(
    .CLK_DIV(4), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .OUT_DELAY(3), .POS_W(5)
  ) dut_b (.clk_i(clk), .reset_ni(rst_n), .enable_i(en), .vga(ifb));

  vga_timing_gen #(
    .CLK_DIV(2), .H_ACTIVE(800), .H_FP(56), .H_SYNC(120), .H_BP(64),
    .V_ACTIVE(600), .V_FP(37), .V_SYNC(6), .V_BP(23),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .OUT_DELAY(0), .POS_W(11)
  ) dut_c (.clk_i(clk), .reset_ni(rst_n), .enable_i(en), .vga(ifc));

  always #5 clk = ~clk;

  // Clock edges since the raster last restarted (reset or disable).
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)   k <= 0;
    else if (!en) k <= 0;
    else          k <= k + 1;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int b2i(bit b);
    return b ? 1 : 0;
  endfunction

  // Raster expected after k clock edges of running: pixel index t = k/div,
  // position = t mod totals; sync/de describe pixel t-dly (nothing before
  // the first tick has been loaded, so those read as idle).
  function automatic obs_t model(cfg_t c, int kk);
    obs_t o;
    int ht, vt, t, ph, p, x, y;
    bit de, hsa, vsa;
    ht = c.ha + c.hf + c.hs + c.hb;
    vt = c.va + c.vf + c.vs + c.vb;
    t  = kk / c.div;
    ph = kk % c.div;
    o.tick = b2i(ph == c.div - 1);
    o.vclk = b2i(ph >= c.div / 2);
    o.h    = t % ht;
    o.v    = (t / ht) % vt;
    o.ls   = b2i(t > 0 && ph == 0 && (t % ht) == 0);
    o.fs   = b2i(t > 0 && ph == 0 && (t % (ht * vt)) == 0);
    de = 1'b0; hsa = 1'b0; vsa = 1'b0;
    p = t - c.dly;
    if (p >= 1) begin
      x   = p % ht;
      y   = (p / ht) % vt;
      de  = (x < c.ha) && (y < c.va);
      hsa = (x >= c.ha + c.hf) && (x < c.ha + c.hf + c.hs);
      vsa = (y >= c.va + c.vf) && (y < c.va + c.vf + c.vs);
    end
    o.de = b2i(de);
    o.hs = b2i(hsa ? c.hp : !c.hp);
    o.vs = b2i(vsa ? c.vp : !c.vp);
    return o;
  endfunction

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", nm, cyc, act, exp);
    end
  endtask

  task automatic cmp(string tag, obs_t a, obs_t e);
    chk({tag, ".pix_tick"}, a.tick, e.tick);
    chk({tag, ".vga_clk"},  a.vclk, e.vclk);
    chk({tag, ".hpos"},     a.h,    e.h);
    chk({tag, ".vpos"},     a.v,    e.v);
    chk({tag, ".de"},       a.de,   e.de);
    chk({tag, ".hsync"},    a.hs,   e.hs);
    chk({tag, ".vsync"},    a.vs,   e.vs);
    chk({tag, ".line_st"},  a.ls,   e.ls);
    chk({tag, ".frame_st"}, a.fs,   e.fs);
  endtask

  // Every-cycle comparison of all three instances against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      obs_t sa, sb, sc;
      sa = '{int'(ifa.pix_tick_o), int'(ifa.VGA_clk_o), int'(ifa.hpos_o), int'(ifa.vpos_o),
             int'(ifa.display_enable_o), int'(ifa.hsync_no), int'(ifa.vsync_no),
             int'(ifa.line_start_o), int'(ifa.frame_start_o)};
      sb = '{int'(ifb.pix_tick_o), int'(ifb.VGA_clk_o), int'(ifb.hpos_o), int'(ifb.vpos_o),
             int'(ifb.display_enable_o), int'(ifb.hsync_no), int'(ifb.vsync_no),
             int'(ifb.line_start_o), int'(ifb.frame_start_o)};
      sc = '{int'(ifc.pix_tick_o), int'(ifc.VGA_clk_o), int'(ifc.hpos_o), int'(ifc.vpos_o),
             int'(ifc.display_enable_o), int'(ifc.hsync_no), int'(ifc.vsync_no),
             int'(ifc.line_start_o), int'(ifc.frame_start_o)};
      cmp("A", sa, model(cfg_a, k));
      cmp("B", sb, model(cfg_b, k));
      cmp("C", sc, model(cfg_c, k));
    end
  end

  initial begin
    int rel;
    int a_fs[$];
    int b_fs[$];
    int a_hs_clk, a_vs_clk, a_de_clk, a_vclk_clk, a_hs_pos;
    int b_hs_clk, b_vs_clk, b_de_clk, b_hs_pos, b_de11, b_de12;
    int c_hs_clk, c_hs_pos;
    int ls_off, fs_off;
    a_hs_clk = 0; a_vs_clk = 0; a_de_clk = 0; a_vclk_clk = 0; a_hs_pos = -1;
    b_hs_clk = 0; b_vs_clk = 0; b_de_clk = 0; b_hs_pos = -1; b_de11 = -1; b_de12 = -1;
    c_hs_clk = 0; c_hs_pos = -1;

    // Reset / idle state, including inactive levels for both polarities.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_on = 1'b1;
    chk("rst_a_hsync", int'(ifa.hsync_no), 1);
    chk("rst_a_vsync", int'(ifa.vsync_no), 1);
    chk("rst_b_hsync", int'(ifb.hsync_no), 0);
    chk("rst_a_de",    int'(ifa.display_enable_o), 0);
    chk("rst_a_hpos",  int'(ifa.hpos_o), 0);

    // Free run for several small frames and most of one 800x600 line.
    @(posedge clk); #1;
    rst_n = 1'b1;
    en    = 1'b1;
    rel   = cyc;
    repeat (2400) begin
      @(negedge clk);
      if (ifa.frame_start_o) a_fs.push_back(cyc - rel);
      if (ifb.frame_start_o) b_fs.push_back(cyc - rel);
      if (a_fs.size() == 1) begin
        if (!ifa.hsync_no)         a_hs_clk++;
        if (!ifa.vsync_no)         a_vs_clk++;
        if (ifa.display_enable_o)  a_de_clk++;
        if (ifa.VGA_clk_o)         a_vclk_clk++;
      end
      if (a_fs.size() >= 1 && a_hs_pos < 0 && !ifa.hsync_no) a_hs_pos = int'(ifa.hpos_o);
      if (b_fs.size() == 1) begin
        if (ifb.hsync_no)          b_hs_clk++;
        if (ifb.vsync_no)          b_vs_clk++;
        if (ifb.display_enable_o)  b_de_clk++;
        if (cyc - rel == b_fs[0] + 11) b_de11 = int'(ifb.display_enable_o);
        if (cyc - rel == b_fs[0] + 12) b_de12 = int'(ifb.display_enable_o);
      end
      if (b_fs.size() >= 1 && b_hs_pos < 0 && ifb.hsync_no) b_hs_pos = int'(ifb.hpos_o);
      if (ifc.hsync_no) begin
        c_hs_clk++;
        if (c_hs_pos < 0) c_hs_pos = int'(ifc.hpos_o);
      end
    end
    chk("a_first_frame_start", (a_fs.size() > 0) ? a_fs[0] : -1, 256);
    chk("a_frame_period",      (a_fs.size() > 1) ? a_fs[1] - a_fs[0] : -1, 256);
    chk("b_first_frame_start", (b_fs.size() > 0) ? b_fs[0] : -1, 512);
    chk("b_frame_period",      (b_fs.size() > 1) ? b_fs[1] - b_fs[0] : -1, 512);
    chk("a_hsync_clks_frame",  a_hs_clk, 48);
    chk("a_vsync_clks_frame",  a_vs_clk, 64);
    chk("a_de_clks_frame",     a_de_clk, 64);
    chk("a_vga_clk_high_clks", a_vclk_clk, 128);
    chk("a_hsync_fall_hpos",   a_hs_pos, 10);
    chk("b_hsync_clks_frame",  b_hs_clk, 96);
    chk("b_vsync_clks_frame",  b_vs_clk, 128);
    chk("b_de_clks_frame",     b_de_clk, 128);
    chk("b_hsync_rise_hpos",   b_hs_pos, 13);
    chk("b_de_before_delay",   b_de11, 0);
    chk("b_de_after_delay",    b_de12, 1);
    chk("c_hsync_clks_line0",  c_hs_clk, 240);
    chk("c_hsync_rise_hpos",   c_hs_pos, 856);
    chk("pkg_800_h_total",     int'(total(VGA_800x600_72.h)), 1040);
    chk("pkg_800_v_total",     int'(total(VGA_800x600_72.v)), 666);
    chk("pkg_640_h_total",     int'(total(VGA_640x480_60.h)), 800);

    // Enable dropped mid-line: raster held idle, then restarts cleanly.
    repeat (7) @(posedge clk); #1;
    en = 1'b0;
    @(posedge clk);
    repeat (10) begin
      @(negedge clk);
      chk("hold_a_hpos",     int'(ifa.hpos_o), 0);
      chk("hold_a_line_st",  int'(ifa.line_start_o), 0);
      chk("hold_c_hsync",    int'(ifc.hsync_no), 0);
    end
    @(posedge clk); #1;
    en  = 1'b1;
    rel = cyc;
    ls_off = -1;
    repeat (40) begin
      @(negedge clk);
      if (ls_off < 0 && ifa.line_start_o) ls_off = cyc - rel;
    end
    chk("a_first_line_start", ls_off, 32);
    repeat (300) @(negedge clk);

    // Asynchronous reset landing mid-tick; idle values seen the same cycle.
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("arst_a_hpos",  int'(ifa.hpos_o), 0);
    chk("arst_b_vpos",  int'(ifb.vpos_o), 0);
    chk("arst_a_vclk",  int'(ifa.VGA_clk_o), 0);
    chk("arst_b_vsync", int'(ifb.vsync_no), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rel   = cyc;
    fs_off = -1;
    repeat (300) begin
      @(negedge clk);
      if (fs_off < 0 && ifa.frame_start_o) fs_off = cyc - rel;
    end
    chk("arst_a_first_frame_start", fs_off, 256);

    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
